// File: rtl/reg_scoreboard_mc_pkg.sv
// ---------------------------------------------------------------------------
// reg_scoreboard_mc_pkg
// Shared constants and types for the multi-count register scoreboard.
//   SB_NUM_REGS / SB_REG_IDX_W / SB_CNT_W / SB_NUM_WB : default geometry
//   lc3b_reg     : architectural register index
//   lc3b_sb_cnt  : per-register in-flight writer count
//   sb_dec_w()   : width needed to hold a per-cycle release count 0..num_wb
// ---------------------------------------------------------------------------
package reg_scoreboard_mc_pkg;

  localparam int SB_NUM_REGS  = 8;
  localparam int SB_REG_IDX_W = 3;
  localparam int SB_CNT_W     = 2;
  localparam int SB_NUM_WB    = 2;

  typedef logic [SB_REG_IDX_W-1:0] lc3b_reg;
  typedef logic [SB_CNT_W-1:0]     lc3b_sb_cnt;

  function automatic int sb_dec_w(input int num_wb);
    return (num_wb < 1) ? 1 : $clog2(num_wb + 1);
  endfunction

endpackage

// File: rtl/reg_scoreboard_mc_sb_counter.sv
// ---------------------------------------------------------------------------
// sb_counter
// One in-flight writer counter for a single architectural register.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (count -> 0)
//   clear      : flush; count -> 0 next edge, inc/dec ignored
//   inc        : one new writer allocated this cycle
//   dec        : number of writers retiring this cycle (0..NUM_WB)
//   zero, one, max : decode of the registered count
//   nz_next    : next-state count is nonzero
//   underflow  : this cycle's update would go negative (clamped to 0)
// ---------------------------------------------------------------------------
module sb_counter #(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec,
  output logic             zero,
  output logic             one,
  output logic             max,
  output logic             nz_next,
  output logic             underflow
);

  // Headroom for sign plus the larger of count and release widths.
  localparam int NET_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 2;

  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic signed [NET_W-1:0] net;

  // Negative results clamp to zero; the upper bound is guaranteed by the
  // issue path refusing to allocate at max.
  function automatic logic [CNT_W-1:0] clamp_low(input logic signed [NET_W-1:0] v);
    if (v < 0) return '0;
    return v[CNT_W-1:0];
  endfunction

  always_comb begin
    net = $signed({{(NET_W-CNT_W){1'b0}}, cnt_q})
        + $signed({{(NET_W-1){1'b0}}, inc})
        - $signed({{(NET_W-DEC_W){1'b0}}, dec});
    underflow = ~clear & (net < 0);
    cnt_d     = clear ? '0 : clamp_low(net);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero    = (cnt_q == '0);
  assign one     = (cnt_q == CNT_W'(1));
  assign max     = &cnt_q;
  assign nz_next = |cnt_d;

endmodule

// File: rtl/reg_scoreboard_mc.sv
// ---------------------------------------------------------------------------
// reg_scoreboard_mc
// Register scoreboard counting in-flight writers per architectural register.
// Allocation comes from issue, release from NUM_WB writeback ports.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   issue_valid  : issuing instruction has a register destination
//   issue_kill   : squash the issue request
//   issue_dest   : destination register of the issuing instruction
//   wb_valid     : per-port writeback strobe
//   wb_dest      : packed writeback destinations, port k at [k*REG_IDX_W +: REG_IDX_W]
//   flush        : discard all in-flight writers
//   ready        : bit i high when register i has no in-flight writer
//   issue_full   : counter[issue_dest] is at maximum (combinational)
//   busy_any     : some counter is nonzero (registered)
//   err          : sticky underflow / illegal index flag, cleared by rst only
// Build option: define SCOREBOARD_WB_BYPASS_EN to forward a same-cycle final
// writeback into ready combinationally.
// ---------------------------------------------------------------------------
module reg_scoreboard_mc
  import reg_scoreboard_mc_pkg::*;
#(
  parameter int NUM_REGS  = SB_NUM_REGS,
  parameter int REG_IDX_W = SB_REG_IDX_W,
  parameter int CNT_W     = SB_CNT_W,
  parameter int NUM_WB    = SB_NUM_WB
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic                        issue_kill,
  input  logic [REG_IDX_W-1:0]        issue_dest,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [NUM_WB*REG_IDX_W-1:0] wb_dest,
  input  logic                        flush,
  output logic [NUM_REGS-1:0]         ready,
  output logic                        issue_full,
  output logic                        busy_any,
  output logic                        err
);

  localparam int DEC_W = sb_dec_w(NUM_WB);

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit WB_BYPASS = 1'b1;
`else
  localparam bit WB_BYPASS = 1'b0;
`endif

  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] cnt_zero;
  logic [NUM_REGS-1:0] cnt_one;
  logic [NUM_REGS-1:0] cnt_max;
  logic [NUM_REGS-1:0] nz_next;
  logic [NUM_REGS-1:0] uflow;
  logic [DEC_W-1:0]    dec_cnt [NUM_REGS];
  logic                issue_fire;
  logic                illegal;
  logic                busy_any_q;
  logic                err_q;

  function automatic logic idx_legal(input logic [REG_IDX_W-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  // Full flag decodes the registered count of the requested destination.
  always_comb begin
    issue_full = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (issue_dest == REG_IDX_W'(i)) issue_full = cnt_max[i];
  end

  assign issue_fire = issue_valid & ~issue_kill & ~issue_full;

  // Port decode: one allocation and a release hit count per register.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i]     = issue_fire & ~flush & (issue_dest == REG_IDX_W'(i));
      dec_cnt[i] = '0;
      for (int k = 0; k < NUM_WB; k++)
        if (wb_valid[k] && !flush && wb_dest[k*REG_IDX_W +: REG_IDX_W] == REG_IDX_W'(i))
          dec_cnt[i] = dec_cnt[i] + DEC_W'(1);
    end
  end

  // Out-of-range indices on any fired port are dropped and flagged.
  always_comb begin
    illegal = 1'b0;
    if (!flush) begin
      if (issue_fire && !idx_legal(issue_dest)) illegal = 1'b1;
      for (int k = 0; k < NUM_WB; k++)
        if (wb_valid[k] && !idx_legal(wb_dest[k*REG_IDX_W +: REG_IDX_W])) illegal = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    sb_counter #(
      .CNT_W (CNT_W),
      .DEC_W (DEC_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .inc       (inc[g]),
      .dec       (dec_cnt[g]),
      .zero      (cnt_zero[g]),
      .one       (cnt_one[g]),
      .max       (cnt_max[g]),
      .nz_next   (nz_next[g]),
      .underflow (uflow[g])
    );
  end

  // The last writer retiring this cycle (with no new writer) can release
  // the register immediately when forwarding is built in.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      ready[i] = cnt_zero[i] |
                 (WB_BYPASS & cnt_one[i] & (dec_cnt[i] != '0) & ~inc[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_any_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      busy_any_q <= |nz_next;
      err_q      <= err_q | illegal | (|uflow);
    end
  end

  assign busy_any = busy_any_q;
  assign err      = err_q;

endmodule

// File: doc/reg_scoreboard_mc.md
Name: reg_scoreboard_mc

Overview:
- Parametrised successor to the single-bit register scoreboard.
- Tracks the number of in-flight writers per architectural register with a saturating up/down counter, instead of a single ready bit.
- Supports NUM_WB writeback ports, issue kill/stall qualification, and a global flush.
- Sits between decode/issue (allocation) and the writeback stages (release); the hazard unit consumes `ready` to stall dependent instructions.

Parameters:
- NUM_REGS, 8, number of tracked architectural registers.
- REG_IDX_W, 3, register index width; must satisfy 2**REG_IDX_W >= NUM_REGS.
- CNT_W, 2, per-register in-flight counter width; maximum count is 2**CNT_W-1.
- NUM_WB, 2, number of independent writeback (release) ports.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  instruction with register destination requests allocation.
- issue_kill  in  1  squash qualifier for the issue request (memory miss, branch stall/taken); when high, no allocation occurs.
- issue_dest  in  REG_IDX_W  destination register of the issuing instruction.
- wb_valid  in  NUM_WB  per-port writeback strobe.
- wb_dest  in  NUM_WB*REG_IDX_W  packed writeback destinations; port k occupies bits [k*REG_IDX_W +: REG_IDX_W].
- flush  in  1  discard all in-flight writers.
- ready  out  NUM_REGS  bit i = 1 when counter[i] == 0.
- issue_full  out  1  combinational; counter[issue_dest] is at maximum.
- busy_any  out  1  registered; some counter is nonzero.
- err  out  1  sticky underflow/illegal-index flag.

Behaviour:
- Reset (synchronous, rst high at a clk edge): all counters 0, `ready` = all ones, `busy_any` = 0, `err` = 0. Reset overrides flush, issue and writeback in the same cycle.
- Allocation:
  - issue_fire = issue_valid & ~issue_kill & ~issue_full.
  - On issue_fire, counter[issue_dest] increments at the clk edge.
  - `ready` deasserts the cycle after issue_fire.
- issue_full:
  - When asserted, the request is not recorded; upstream must hold the instruction.
  - `issue_full` is valid regardless of issue_valid.
- Release: each wb_valid[k] decrements counter[wb_dest[k]] by 1. Multiple ports hitting the same register in one cycle decrement by the number of hits.
- Net update per register per cycle: next = cnt + inc - dec, where inc ∈ {0,1} and dec ∈ 0..NUM_WB.
  - Computed in CNT_W+2 bits.
  - Result < 0: clamp to 0 and set `err`.
  - inc is already blocked at maximum, so no overflow is possible.
- Simultaneous issue and writeback to the same register at count 0: net 0, `ready` stays 1. At count 1: stays 1.
- Index >= NUM_REGS on any fired port: ignored and `err` set.
- Flush:
  - All counters are cleared next edge.
  - Issue and writeback in the flush cycle are ignored.
  - `err` is not cleared.
- Latency: all outputs except `issue_full` reflect state registered at the previous edge, with no bypass (default).
- `err` clears only on rst.

Optional Feature:
- SCOREBOARD_WB_BYPASS_EN
  - Defined: `ready[i]` is additionally forced high combinationally when counter[i] == 1 and a same-cycle wb_valid targets i with no concurrent issue_fire to i. This gives zero-cycle forwarding to the hazard unit.
  - Undefined: `ready` is purely registered, as described in Behaviour.

Decomposition:
- Add to lc3b_types:
  - Constants SB_NUM_REGS and SB_CNT_W.
  - Typedef lc3b_sb_cnt (logic [CNT_W-1:0]).
  - Reuse lc3b_reg for indices.
- Sub-module sb_counter: one per register. Inputs inc, dec count, clear; outputs zero, max, underflow.
- Top level generates NUM_REGS instances plus port decode logic.

Test Plan:
- Reset, then idle 2 cycles -> `ready`=8'hFF, `busy_any`=0, `err`=0.
- Issue R3 three times (CNT_W=2) -> `ready[3]`=0 after first edge. Fourth issue to R3 -> `issue_full`=1 and counter stays 3. Three writebacks to R3 -> `ready[3]`=1 after the third.
- R5 at count 1; wb_valid=2'b11 with both ports on R5 -> counter 0, `err`=1 (underflow clamped). Next cycle `ready[5]`=1.
- issue_valid on R2 with issue_kill=1 -> `ready[2]` stays 1. Same request with issue_kill=0 -> `ready[2]`=0 next cycle.
- R1 and R6 busy; flush together with issue R4 and wb R1 -> next cycle `ready`=8'hFF, `busy_any`=0.
- With SCOREBOARD_WB_BYPASS_EN: R7 at count 1, wb R7 -> `ready[7]`=1 in the same cycle. Without the macro -> `ready[7]`=1 only next cycle.
